// File: rtl/vend_dispense_sched.sv
// Dispense scheduler: queues cola and change requests from the vending FSM and
// drives one actuator at a time, round-robin, with done handshake, gap and timeout.
module vend_dispense_sched #(
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 1000,
  parameter int GAP     = 4,
  parameter int TMR_W   = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pi_cola_req,
  input  logic             pi_change_req,
  input  logic             pi_cola_done,
  input  logic             pi_coin_done,
  input  logic             pi_fault_clr,
  output logic             po_cola_motor,
  output logic             po_coin_eject,
  output logic             po_busy,
  output logic             po_fault,
  output logic             po_overflow,
  output logic [CNT_W-1:0] po_cola_pend,
  output logic [CNT_W-1:0] po_change_pend
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLA_ON,
    S_COIN_ON,
    S_GAP,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             last_cola;
  logic             grant_cola, grant_coin;
  logic [CNT_W-1:0] cola_nxt, coin_nxt;
  logic             ovf_cola, ovf_coin;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    grant_cola = 1'b0;
    grant_coin = 1'b0;
    case (state)
      S_IDLE: begin
        // on a tie, serve the queue that was not granted last
        if (po_cola_pend != '0 && (po_change_pend == '0 || !last_cola)) begin
          grant_cola = 1'b1;
        end else if (po_change_pend != '0) begin
          grant_coin = 1'b1;
        end
        if (grant_cola) begin
          state_nxt = S_COLA_ON;
          timer_nxt = '0;
        end else if (grant_coin) begin
          state_nxt = S_COIN_ON;
          timer_nxt = '0;
        end
      end
      S_COLA_ON: begin
        if (pi_cola_done) begin
          state_nxt = S_GAP;
          timer_nxt = '0;
        end else if (timer == TMO_LAST) begin
          state_nxt = S_FAULT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_COIN_ON: begin
        if (pi_coin_done) begin
          state_nxt = S_GAP;
          timer_nxt = '0;
        end else if (timer == TMO_LAST) begin
          state_nxt = S_FAULT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_GAP: begin
        if (timer == GAP_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_FAULT: begin
        if (pi_fault_clr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A request and a grant in the same cycle cancel; a request at saturation drops.
  always_comb begin
    cola_nxt = po_cola_pend;
    ovf_cola = 1'b0;
    case ({pi_cola_req, grant_cola})
      2'b10: begin
        if (po_cola_pend == CNT_MAX) ovf_cola = 1'b1;
        else cola_nxt = po_cola_pend + 1'b1;
      end
      2'b01:   cola_nxt = po_cola_pend - 1'b1;
      default: cola_nxt = po_cola_pend;
    endcase
  end

  always_comb begin
    coin_nxt = po_change_pend;
    ovf_coin = 1'b0;
    case ({pi_change_req, grant_coin})
      2'b10: begin
        if (po_change_pend == CNT_MAX) ovf_coin = 1'b1;
        else coin_nxt = po_change_pend + 1'b1;
      end
      2'b01:   coin_nxt = po_change_pend - 1'b1;
      default: coin_nxt = po_change_pend;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= S_IDLE;
      timer          <= '0;
      last_cola      <= 1'b0;
      po_cola_pend   <= '0;
      po_change_pend <= '0;
      po_overflow    <= 1'b0;
      po_cola_motor  <= 1'b0;
      po_coin_eject  <= 1'b0;
      po_busy        <= 1'b0;
      po_fault       <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      po_cola_pend   <= cola_nxt;
      po_change_pend <= coin_nxt;
      if (grant_cola)      last_cola <= 1'b1;
      else if (grant_coin) last_cola <= 1'b0;
      // a drop in the same cycle as a clear is newer, so it stays visible
      if (ovf_cola || ovf_coin) po_overflow <= 1'b1;
      else if (pi_fault_clr)    po_overflow <= 1'b0;
      po_cola_motor  <= (state_nxt == S_COLA_ON);
      po_coin_eject  <= (state_nxt == S_COIN_ON);
      po_busy        <= (state_nxt != S_IDLE);
      po_fault       <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Bench for vend_dispense_sched: table-driven first dispense, directed corner
// sequences, and random traffic against a queue/timer reference model.
module tb_vend_dispense_sched;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 1000;
  localparam int GAP     = 4;
  localparam int TMR_W   = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cola_req = 1'b0, change_req = 1'b0, cola_done = 1'b0, coin_done = 1'b0, fault_clr = 1'b0;
  logic motor, eject, busy, fault, ovf;
  logic [CNT_W-1:0] cola_pend, change_pend;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  vend_dispense_sched #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .GAP(GAP), .TMR_W(TMR_W)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .pi_cola_req(cola_req), .pi_change_req(change_req),
    .pi_cola_done(cola_done), .pi_coin_done(coin_done), .pi_fault_clr(fault_clr),
    .po_cola_motor(motor), .po_coin_eject(eject), .po_busy(busy), .po_fault(fault),
    .po_overflow(ovf), .po_cola_pend(cola_pend), .po_change_pend(change_pend)
  );

  always #5 clk = ~clk;

  // Reference model: queue depths, which actuator is on and for how long,
  // remaining gap cycles, fault flag, and which queue wins the next tie.
  int m_q[2];
  int m_act;
  int m_on;
  int m_gap;
  bit m_fault;
  bit m_ovf;
  int m_pref;

  task automatic model_reset();
    m_q[0] = 0; m_q[1] = 0;
    m_act = -1; m_on = 0; m_gap = 0;
    m_fault = 0; m_ovf = 0; m_pref = 0;
  endtask

  task automatic model_step();
    int grant;
    bit req[2];
    bit done;
    grant = -1;
    req[0] = cola_req;
    req[1] = change_req;
    if (m_act < 0 && m_gap == 0 && !m_fault) begin
      if (m_q[0] > 0 && m_q[1] > 0) grant = m_pref;
      else if (m_q[0] > 0)          grant = 0;
      else if (m_q[1] > 0)          grant = 1;
    end
    if (fault_clr) m_ovf = 0;
    for (int i = 0; i < 2; i++) begin
      if (req[i] && grant != i) begin
        if (m_q[i] == CMAX) m_ovf = 1;
        else m_q[i]++;
      end else if (!req[i] && grant == i) begin
        m_q[i]--;
      end
    end
    if (m_fault) begin
      if (fault_clr) m_fault = 0;
    end else if (m_act >= 0) begin
      done = (m_act == 0) ? cola_done : coin_done;
      if (done) begin
        m_act = -1; m_gap = GAP;
      end else if (m_on == TIMEOUT) begin
        m_act = -1; m_fault = 1;
      end else begin
        m_on++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (grant >= 0) begin
      m_act = grant; m_on = 1; m_pref = 1 - grant;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic check_model();
    logic [4+2*CNT_W:0] got_v, exp_v;
    got_v = {motor, eject, busy, fault, ovf, cola_pend, change_pend};
    exp_v = {m_act == 0, m_act == 1, (m_act >= 0) || (m_gap > 0) || m_fault,
             m_fault, m_ovf, CNT_W'(m_q[0]), CNT_W'(m_q[1])};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t got {motor,eject,busy,fault,ovf,cpend,npend}=%b expected %b",
               $time, got_v, exp_v);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input bit cr, input bit chr, input bit cd, input bit kd, input bit fc);
    @(negedge clk);
    if (chk_en) check_model();
    cola_req = cr; change_req = chr; cola_done = cd; coin_done = kd; fault_clr = fc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    cola_req = 0; change_req = 0; cola_done = 0; coin_done = 0; fault_clr = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return motor;
      1:       return eject;
      2:       return fault;
      default: return busy;
    endcase
  endfunction

  task automatic wait_until(input string name, input int which, input logic val,
                            input int budget, output int n);
    n = 0;
    while (sig(which) !== val && n < budget) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (sig(which) !== val) begin
      errors++;
      $display("FAIL %s not reached after %0d cycles", name, n);
    end
  endtask

  typedef struct {
    bit cr;
    bit cd;
    bit motor;
    bit busy;
    int pend;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n, on_cnt, idle_run, min_idle, pulses, h;
    int order[$];

    // one cola request, done sensor in the 5th motor cycle
    tbl[0]  = '{1, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 1, 1, 0};
    tbl[2]  = '{0, 0, 1, 1, 0};
    tbl[3]  = '{0, 0, 1, 1, 0};
    tbl[4]  = '{0, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 1, 1, 0};
    tbl[6]  = '{0, 1, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0};

    do_reset();
    chk("rst_motor", motor, 0);
    chk("rst_eject", eject, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cola_pend", cola_pend, 0);
    chk("rst_change_pend", change_pend, 0);
    chk_en = 1;

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].cr, 0, tbl[i].cd, 0, 0);
      chk($sformatf("tbl%0d_motor", i), motor, tbl[i].motor);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_pend", i), cola_pend, tbl[i].pend);
    end

    // round robin: both requests twice, sensors answer after 3 on-cycles
    do_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    on_cnt = 0; idle_run = 0; min_idle = 1000; pulses = 0;
    for (int k = 0; k < 200 && pulses < 4; k++) begin
      bit cd, kd;
      cd = 0; kd = 0;
      if (motor || eject) begin
        if (on_cnt == 0) begin
          order.push_back(motor ? 0 : 1);
          if (pulses > 0 && idle_run < min_idle) min_idle = idle_run;
        end
        on_cnt++;
        idle_run = 0;
        if (on_cnt == 3) begin
          cd = motor; kd = eject; pulses++; on_cnt = 0;
        end
      end else begin
        idle_run++;
      end
      cyc(0, 0, cd, kd, 0);
    end
    chk("rr_pulses", pulses, 4);
    chk("rr_order_len", order.size(), 4);
    if (order.size() == 4) begin
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 0);
      chk("rr_order3", order[3], 1);
    end
    chk("rr_min_idle_ge4", int'(min_idle >= 4), 1);

    // saturation while the motor is stalled, then timeout and fault clear
    do_reset();
    cyc(1, 0, 0, 0, 0);
    wait_until("sat_motor_on", 0, 1'b1, 10, n);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (k == 6) begin
        chk("sat_pend_at7", cola_pend, 7);
        chk("sat_no_ovf_yet", ovf, 0);
      end
    end
    chk("sat_pend", cola_pend, 7);
    chk("sat_ovf", ovf, 1);
    chk("sat_motor_stalled", motor, 1);
    wait_until("tmo_motor_off", 0, 1'b0, TIMEOUT + 20, n);
    chk("tmo_on_cycles", 8 + n, TIMEOUT);
    chk("tmo_fault", fault, 1);
    chk("tmo_motor", motor, 0);
    chk("tmo_pend_kept", cola_pend, 7);
    cyc(0, 0, 0, 0, 1);
    chk("clr_fault", fault, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_busy", busy, 0);
    wait_until("clr_resume", 0, 1'b1, 3, n);
    chk("clr_resume_pend", cola_pend, 6);

    // request accepted during FAULT
    do_reset();
    cyc(1, 0, 0, 0, 0);
    wait_until("flt_motor_on", 0, 1'b1, 10, n);
    wait_until("flt_fault", 2, 1'b1, TIMEOUT + 20, n);
    chk("flt_pend_before", cola_pend, 0);
    cyc(1, 0, 0, 0, 0);
    chk("flt_pend_after", cola_pend, 1);
    chk("flt_still_fault", fault, 1);

    // done on the same cycle the timer reaches TIMEOUT-1
    do_reset();
    cyc(1, 0, 0, 0, 0);
    wait_until("edge_motor_on", 0, 1'b1, 10, n);
    h = 1;
    while (h < TIMEOUT) begin
      cyc(0, 0, 0, 0, 0);
      h++;
    end
    chk("edge_motor_last", motor, 1);
    cyc(0, 0, 1, 0, 0);
    chk("edge_fault", fault, 0);
    chk("edge_motor_off", motor, 0);
    chk("edge_busy_gap", busy, 1);

    // wrong sensor is ignored
    do_reset();
    cyc(1, 0, 0, 0, 0);
    wait_until("xs_motor_on", 0, 1'b1, 10, n);
    cyc(0, 0, 0, 1, 0);
    chk("xs_motor_stays", motor, 1);
    cyc(0, 0, 1, 0, 0);
    chk("xs_motor_off", motor, 0);

    // reset mid COIN_ON
    do_reset();
    cyc(0, 1, 0, 0, 0);
    wait_until("rmid_eject_on", 1, 1'b1, 10, n);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rmid_cola_pend", cola_pend, 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid_eject_async", eject, 0);
    chk("rmid_cola_pend0", cola_pend, 0);
    chk("rmid_change_pend0", change_pend, 0);
    chk("rmid_busy", busy, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // random traffic: responsive sensors, then mostly silent sensors
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 63) == 0);
    for (int k = 0; k < 2500; k++)
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 999) == 0, $urandom_range(0, 999) == 0,
          $urandom_range(0, 63) == 0);
    cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
